// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared constants for the SPI target peripheral.
//   - Register map (CTRL, STAT, DATA) as a typed address enum.
//   - Bit positions and single-bit masks for the CTRL and STAT registers.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    ADDR_CTRL = 2'd0,
    ADDR_STAT = 2'd1,
    ADDR_DATA = 2'd2
  } reg_addr_e;

  // Number of implemented bits in CTRL (the rest read as zero).
  localparam int CTRL_W = 5;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CPHA   = 1;
  localparam int CTRL_CPOL   = 2;
  localparam int CTRL_RXNEIE = 3;
  localparam int CTRL_TXEIE  = 4;

  // STAT bit positions
  localparam int STAT_RXNE = 0;
  localparam int STAT_TXE  = 1;
  localparam int STAT_OVR  = 2;
  localparam int STAT_UDR  = 3;
  localparam int STAT_BSY  = 4;

  // Single-bit masks for software-side register composition
  localparam logic [7:0] CTRL_EN_M     = 8'h01;
  localparam logic [7:0] CTRL_CPHA_M   = 8'h02;
  localparam logic [7:0] CTRL_CPOL_M   = 8'h04;
  localparam logic [7:0] CTRL_RXNEIE_M = 8'h08;
  localparam logic [7:0] CTRL_TXEIE_M  = 8'h10;

  localparam logic [7:0] STAT_RXNE_M = 8'h01;
  localparam logic [7:0] STAT_TXE_M  = 8'h02;
  localparam logic [7:0] STAT_OVR_M  = 8'h04;
  localparam logic [7:0] STAT_UDR_M  = 8'h08;
  localparam logic [7:0] STAT_BSY_M  = 8'h10;

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: peripheral-bus control strobes plus the SPI pin set.
//   master modport: CPU bus side and external SPI master (drive strobes, cs, sck, mosi).
//   slave  modport: the spi_slave block (drives interrupt, miso, miso_oe).
// The tri-state bus_data line is kept as a plain inout port of the block.
interface spi_slave_if #(
  parameter int PERIPH_N = 2
);
  logic                bus_we;
  logic                bus_oe;
  logic                periph_sel;
  logic [PERIPH_N-1:0] periph_addr;
  logic                interrupt;
  logic                cs;
  logic                sck;
  logic                mosi;
  logic                miso;
  logic                miso_oe;

  modport master (
    output bus_we, bus_oe, periph_sel, periph_addr, cs, sck, mosi,
    input  interrupt, miso, miso_oe
  );

  modport slave (
    input  bus_we, bus_oe, periph_sel, periph_addr, cs, sck, mosi,
    output interrupt, miso, miso_oe
  );

endinterface

// File: rtl/spi_slave_sync_edge.sv
// sync_edge: two-flop synchronizer for an asynchronous input, plus
// single-cycle rise/fall pulses derived from the synchronized level.
//   clk, n_reset : peripheral clock, async active-low reset
//   d            : asynchronous input
//   q            : synchronized level
//   rise, fall   : one-clk pulses on synchronized 0->1 / 1->0
//   INIT         : reset value of all stages (the pin's idle level)
module sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta, sync, prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a true shift chain.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta <= INIT;
      sync <= INIT;
      prev <= INIT;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign q    = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: memory-mapped SPI target with double-buffered TX/RX bytes.
//   clk, n_reset : peripheral clock (>= 8x sck), async active-low reset
//   bus          : spi_slave_if.slave -- bus strobes, address, interrupt,
//                  SPI pins cs/sck/mosi in, miso/miso_oe out
//   bus_data     : tri-state data bus, driven only during a selected read
// cs/sck/mosi are oversampled in the clk domain; nothing is clocked by sck.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_N   = 8,
  parameter int PERIPH_N = 2
) (
  input  logic              clk,
  input  logic              n_reset,
  spi_slave_if.slave        bus,
  inout  wire  [DATA_N-1:0] bus_data
);

  localparam int CNT_W = $clog2(DATA_N);

  // Registers
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_N-1:0] tx_buf, rx_buf, tx_sh, rx_sh;
  logic [CNT_W-1:0]  cnt;
  logic              rxne, txe, ovr, udr;
  logic              miso_q;
  logic              mosi_meta, mosi_sync;

  // Synchronized SPI inputs
  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;

  sync_edge #(.INIT(1'b0)) u_sck_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (bus.sck),
    .q       (sck_sync),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  // cs idles high, so its synchronizer resets high to avoid a fake frame start.
  sync_edge #(.INIT(1'b1)) u_cs_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (bus.cs),
    .q       (cs_sync),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= bus.mosi;
      mosi_sync <= mosi_meta;
    end
  end

  // Control decode
  logic en, cpha, cpol, rxneie, txeie, active;
  assign en     = ctrl[CTRL_EN];
  assign cpha   = ctrl[CTRL_CPHA];
  assign cpol   = ctrl[CTRL_CPOL];
  assign rxneie = ctrl[CTRL_RXNEIE];
  assign txeie  = ctrl[CTRL_TXEIE];
  assign active = en & ~cs_sync;

  // Bus access decode
  logic rd_sel, wr_ctrl, wr_data, rd_data, rd_stat;
  assign rd_sel  = bus.periph_sel & bus.bus_oe;
  assign wr_ctrl = bus.periph_sel & bus.bus_we & (bus.periph_addr == PERIPH_N'(ADDR_CTRL));
  assign wr_data = bus.periph_sel & bus.bus_we & (bus.periph_addr == PERIPH_N'(ADDR_DATA));
  assign rd_data = rd_sel & (bus.periph_addr == PERIPH_N'(ADDR_DATA));
  assign rd_stat = rd_sel & (bus.periph_addr == PERIPH_N'(ADDR_STAT));

  // SPI event decode. Sampling happens on the leading edge when CPHA=0 and
  // the trailing edge when CPHA=1; with CPOL folded in, that is a rising
  // edge exactly when CPOL==CPHA.
  logic sample_edge, shift_edge;
  logic frame_start, abort, do_sample, do_shift, frame_done, tx_load;
  logic accept, overrun, underrun;
  logic [DATA_N-1:0] tx_load_val, rx_byte;

  assign sample_edge = (cpol == cpha) ? sck_rise : sck_fall;
  assign shift_edge  = (cpol == cpha) ? sck_fall : sck_rise;

  assign frame_start = en & cs_fall;
  assign abort       = en & cs_rise;
  assign do_sample   = active & ~cs_fall & sample_edge;
  assign frame_done  = do_sample & (cnt == CNT_W'(DATA_N - 1));
  // No shift before the first sample: keeps the MSB on miso for the whole
  // first bit in CPHA=1 and after each reload in back-to-back frames.
  assign do_shift    = active & ~cs_fall & shift_edge & (cnt != '0);
  assign tx_load     = frame_start | frame_done;

  // A write landing on the load cycle goes straight into the shift register.
  assign tx_load_val = wr_data ? bus_data : (txe ? '1 : tx_buf);
  assign underrun    = tx_load & txe & ~wr_data;
  assign rx_byte     = {rx_sh[DATA_N-2:0], mosi_sync};
  // A DATA read in the completion cycle frees the buffer for the new byte.
  assign accept      = frame_done & (~rxne | rd_data);
  assign overrun     = frame_done & rxne & ~rd_data;

  // CTRL: only reset clears it; EN=0 leaves the other bits programmable.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)     ctrl <= '0;
    else if (wr_ctrl) ctrl <= bus_data[CTRL_W-1:0];
  end

  // Byte buffers
  // NOTE: the buffers are plain flops (not a RAM), so they take the async
  // reset and the EN=0 clear like any other state.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      tx_buf <= '0;
      rx_buf <= '0;
    end else if (!en) begin
      tx_buf <= '0;
      rx_buf <= '0;
    end else begin
      if (wr_data) tx_buf <= bus_data;
      if (accept)  rx_buf <= rx_byte;
    end
  end

  // Shift registers, bit counter and registered miso
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      tx_sh  <= '0;
      rx_sh  <= '0;
      cnt    <= '0;
      miso_q <= 1'b0;
    end else if (!en) begin
      tx_sh  <= '0;
      rx_sh  <= '0;
      cnt    <= '0;
      miso_q <= 1'b0;
    end else begin
      if (abort) begin
        cnt   <= '0;
        rx_sh <= '0;
      end else if (frame_start) begin
        cnt   <= '0;
        rx_sh <= '0;
        tx_sh <= tx_load_val;
      end else if (do_sample) begin
        rx_sh <= rx_byte;
        if (frame_done) begin
          cnt   <= '0;
          tx_sh <= tx_load_val;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (do_shift) begin
        tx_sh <= {tx_sh[DATA_N-2:0], 1'b0};
      end
      miso_q <= tx_sh[DATA_N-1];
    end
  end

  // Status flags: a set event in the same cycle as its clear wins.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rxne <= 1'b0;
      txe  <= 1'b1;
      ovr  <= 1'b0;
      udr  <= 1'b0;
    end else if (!en) begin
      rxne <= 1'b0;
      txe  <= 1'b1;
      ovr  <= 1'b0;
      udr  <= 1'b0;
    end else begin
      if (accept)       rxne <= 1'b1;
      else if (rd_data) rxne <= 1'b0;

      if (tx_load)      txe <= 1'b1;
      else if (wr_data) txe <= 1'b0;

      if (overrun)      ovr <= 1'b0 | 1'b1;
      else if (rd_stat) ovr <= 1'b0;

      if (underrun)     udr <= 1'b1;
      else if (rd_stat) udr <= 1'b0;
    end
  end

  // Read mux
  logic [DATA_N-1:0] rd_val;

  // NOTE: rd_val gets a default before any branch so every path assigns it
  // and no latch is inferred.
  always_comb begin
    rd_val = '0;
    if (bus.periph_addr == PERIPH_N'(ADDR_CTRL)) begin
      rd_val[CTRL_W-1:0] = ctrl;
    end else if (bus.periph_addr == PERIPH_N'(ADDR_STAT)) begin
      rd_val[STAT_RXNE] = rxne;
      rd_val[STAT_TXE]  = txe;
      rd_val[STAT_OVR]  = ovr;
      rd_val[STAT_UDR]  = udr;
      rd_val[STAT_BSY]  = active;
    end else if (bus.periph_addr == PERIPH_N'(ADDR_DATA)) begin
      rd_val = rx_buf;
    end
  end

  assign bus_data = rd_sel ? rd_val : {DATA_N{1'bz}};

  assign bus.miso      = miso_q;
  assign bus.miso_oe   = active;
  assign bus.interrupt = (rxneie & (rxne | ovr)) | (txeie & (txe | udr));

endmodule
